// File: rtl/cordic_pkg.sv
// Shared constants, FSM state type and lane pack/unpack helpers for the CORDIC pair scheduler.
package cordic_pkg;
  localparam int WIDTH           = 24;
  localparam int N_LANE          = 8;
  localparam int WIDTH_INDEX     = 3;
  localparam int WIDTH_SHIFT_BIT = 4;
  localparam int NUM_ITER        = 16;
  localparam int BUS_W           = 2 * N_LANE * WIDTH;

  localparam logic [WIDTH_SHIFT_BIT-1:0] LAST_ITER = WIDTH_SHIFT_BIT'(NUM_ITER - 1);
  localparam logic [2:0]                 LAST_LANE = 3'(N_LANE - 1);

  typedef logic [WIDTH-1:0]    word_t;
  typedef word_t [N_LANE-1:0]  lane_vec_t;
  typedef logic [BUS_W-1:0]    pair_bus_t;

  typedef enum logic [2:0] {IDLE, LOAD, ROTATE, CAPTURE, DRAIN} state_t;

  // Bus layout is {y7..y0, x7..x0}; lane 0 sits in the least significant word.
  function automatic pair_bus_t pack_pair(input lane_vec_t x, input lane_vec_t y);
    return {y, x};
  endfunction

  function automatic lane_vec_t unpack_x(input pair_bus_t b);
    return b[N_LANE*WIDTH-1:0];
  endfunction

  function automatic lane_vec_t unpack_y(input pair_bus_t b);
    return b[BUS_W-1:N_LANE*WIDTH];
  endfunction
endpackage

// File: rtl/cordic_gain_comp.sv
// Combinational CORDIC gain compensation: dout = din * (2^-1 + 2^-3 - 2^-6 - 2^-9),
// each term an arithmetic right shift (truncating), sum wrapping at WIDTH.
module cordic_gain_comp
  import cordic_pkg::*;
(
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic signed [WIDTH-1:0] s;

  assign s    = signed'(din);
  assign dout = $unsigned((s >>> 1) + (s >>> 3) - (s >>> 6) - (s >>> 9));
endmodule

// File: rtl/cordic_pair_sched.sv
// Load / rotate / capture / drain sequencer around the 2x8 CORDIC array.
// Optional macro SCALE_COMP_EN adds a second CAPTURE cycle applying the CORDIC gain correction.
module cordic_pair_sched
  import cordic_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_x,
  input  logic [WIDTH-1:0]           in_y,
  input  logic [WIDTH_INDEX-1:0]     in_index,
  output logic [BUS_W-1:0]           arr_data_in,
  output logic [WIDTH_INDEX-1:0]     arr_index,
  output logic                       arr_ce0,
  output logic                       arr_ce1,
  input  logic [WIDTH_SHIFT_BIT-1:0] arr_count,
  input  logic [BUS_W-1:0]           arr_data_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_x,
  output logic [WIDTH-1:0]           out_y,
  output logic                       out_last,
  output logic                       busy
);
  // Handshakes: a beat transfers on the rising edge where valid & ready are both high;
  // valid never waits on ready, and the producer holds data stable until the transfer.
  state_t                     state;
  logic [2:0]                 ptr;
  lane_vec_t                  ld_x, ld_y, res_x, res_y, cap_x, cap_y;
  logic [WIDTH_SHIFT_BIT-1:0] rot_cnt;
  logic                       in_fire, out_fire, rot_done;

  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;
  assign rot_done    = arr_ce1 && (arr_count == LAST_ITER) && (rot_cnt == LAST_ITER);
  assign arr_data_in = pack_pair(ld_x, ld_y);
  assign out_x       = res_x[ptr];
  assign out_y       = res_y[ptr];
  assign busy        = (state != IDLE);

  // A pivot of 4 or more never enables the lower group, so those lanes bypass the array.
  always_comb begin
    cap_x = unpack_x(arr_data_out);
    cap_y = unpack_y(arr_data_out);
    if (arr_index[WIDTH_INDEX-1]) begin
      for (int i = 0; i < N_LANE / 2; i++) begin
        cap_x[i] = ld_x[i];
        cap_y[i] = ld_y[i];
      end
    end
  end

`ifdef SCALE_COMP_EN
  lane_vec_t scl_x, scl_y;
  logic      cap_second;

  for (genvar g = 0; g < N_LANE; g++) begin : g_gain
    cordic_gain_comp u_gain_x (.din(res_x[g]), .dout(scl_x[g]));
    cordic_gain_comp u_gain_y (.din(res_y[g]), .dout(scl_y[g]));
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      ld_x      <= '0;
      ld_y      <= '0;
      res_x     <= '0;
      res_y     <= '0;
      arr_index <= '0;
      arr_ce0   <= 1'b0;
      arr_ce1   <= 1'b0;
      rot_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
`ifdef SCALE_COMP_EN
      cap_second <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            ld_x[0]   <= in_x;
            ld_y[0]   <= in_y;
            arr_index <= in_index;
            ptr       <= 3'd1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (in_fire) begin
            ld_x[ptr] <= in_x;
            ld_y[ptr] <= in_y;
            ptr       <= ptr + 3'd1;
            if (ptr == LAST_LANE) begin
              state    <= ROTATE;
              in_ready <= 1'b0;
              arr_ce1  <= 1'b1;
              arr_ce0  <= ~arr_index[WIDTH_INDEX-1];
              rot_cnt  <= '0;
            end
          end
        end
        ROTATE: begin
          // Local count guarantees at least NUM_ITER enabled cycles whatever the array reports.
          if (rot_cnt != LAST_ITER) rot_cnt <= rot_cnt + WIDTH_SHIFT_BIT'(1);
          if (rot_done) begin
            state   <= CAPTURE;
            arr_ce0 <= 1'b0;
            arr_ce1 <= 1'b0;
          end
        end
        CAPTURE: begin
`ifdef SCALE_COMP_EN
          if (!cap_second) begin
            res_x      <= cap_x;
            res_y      <= cap_y;
            cap_second <= 1'b1;
          end else begin
            res_x      <= scl_x;
            res_y      <= scl_y;
            cap_second <= 1'b0;
            state      <= DRAIN;
            out_valid  <= 1'b1;
          end
`else
          res_x     <= cap_x;
          res_y     <= cap_y;
          state     <= DRAIN;
          out_valid <= 1'b1;
`endif
        end
        DRAIN: begin
          if (out_fire) begin
            ptr      <= ptr + 3'd1;
            out_last <= (ptr == LAST_LANE - 3'd1);
            if (ptr == LAST_LANE) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_pair_sched.sv
// Self-checking bench for cordic_pair_sched with an ideal CORDIC array model and job-level reference.
module tb_cordic_pair_sched;
  import cordic_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_x = '0;
  logic [WIDTH-1:0]           in_y = '0;
  logic [WIDTH_INDEX-1:0]     in_index = '0;
  logic [BUS_W-1:0]           arr_data_in;
  logic [WIDTH_INDEX-1:0]     arr_index;
  logic                       arr_ce0, arr_ce1;
  logic [WIDTH_SHIFT_BIT-1:0] arr_count = '0;
  logic [BUS_W-1:0]           arr_data_out;
  logic                       out_valid;
  logic                       out_ready = 1'b0;
  logic [WIDTH-1:0]           out_x, out_y;
  logic                       out_last, busy;

  int checks = 0;
  int errors = 0;
  logic [2*WIDTH-1:0] exp_q[$];

  word_t                  ld_x[N_LANE];
  word_t                  ld_y[N_LANE];
  logic [WIDTH_INDEX-1:0] ld_idx = '0;
  logic [BUS_W-1:0]       rot_mask = '0;
  logic [BUS_W-1:0]       direct_bus = '0;
  logic                   use_direct = 1'b0;

  cordic_pair_sched dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_index(in_index),
    .arr_data_in(arr_data_in), .arr_index(arr_index), .arr_ce0(arr_ce0), .arr_ce1(arr_ce1),
    .arr_count(arr_count), .arr_data_out(arr_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_last(out_last), .busy(busy)
  );

  // ---------------- clock / ideal array ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n || !(arr_ce0 || arr_ce1)) arr_count <= '0;
    else arr_count <= WIDTH_SHIFT_BIT'(arr_count + 1);
  end

  assign arr_data_out = use_direct ? direct_bus : (arr_data_in ^ rot_mask);

  // ---------------- reference model ----------------
  function automatic logic [BUS_W-1:0] load_bus();
    logic [BUS_W-1:0] b;
    for (int i = 0; i < N_LANE; i++) begin
      b[i*WIDTH +: WIDTH]          = ld_x[i];
      b[(N_LANE+i)*WIDTH +: WIDTH] = ld_y[i];
    end
    return b;
  endfunction

`ifdef SCALE_COMP_EN
  function automatic word_t k_mul(input word_t v);
    logic signed [WIDTH-1:0] s;
    s = v;
    return word_t'((s >>> 1) + (s >>> 3) - (s >>> 6) - (s >>> 9));
  endfunction
`endif

  task automatic predict();
    logic [BUS_W-1:0] ret;
    word_t ex, ey;
    ret = use_direct ? direct_bus : (load_bus() ^ rot_mask);
    for (int i = 0; i < N_LANE; i++) begin
      ex = ret[i*WIDTH +: WIDTH];
      ey = ret[(N_LANE+i)*WIDTH +: WIDTH];
      if (ld_idx >= 3'd4 && i < 4) begin
        ex = ld_x[i];
        ey = ld_y[i];
      end
`ifdef SCALE_COMP_EN
      ex = k_mul(ex);
      ey = k_mul(ey);
`endif
      exp_q.push_back({ey, ex});
    end
  endtask

  task automatic gen_job(input logic [WIDTH_INDEX-1:0] idx);
    for (int i = 0; i < N_LANE; i++) begin
      ld_x[i] = word_t'($urandom);
      ld_y[i] = word_t'($urandom);
    end
    for (int k = 0; k < BUS_W / 32; k++) rot_mask[k*32 +: 32] = $urandom;
    ld_idx = idx;
  endtask

  // ---------------- drivers / monitors ----------------
  task automatic drive_load(input int gap);
    for (int i = 0; i < N_LANE; i++) begin
      int waited;
      waited = 0;
      for (int g = 0; i > 0 && g < gap; g++) begin
        @(negedge clk);
        checks++;
        if ({in_ready, arr_ce1} !== 2'b10) begin
          errors++;
          $display("FAIL load_gap lane %0d ready/ce1 got %b exp 10", i, {in_ready, arr_ce1});
        end
      end
      in_valid = 1'b1;
      in_x     = ld_x[i];
      in_y     = ld_y[i];
      in_index = (i == 0) ? ld_idx : WIDTH_INDEX'($urandom_range(0, 7));
      while (!in_ready && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready lane %0d got %b exp 1", i, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_x     = word_t'($urandom);
      in_y     = word_t'($urandom);
    end
  endtask

  task automatic watch_rotate();
    int ce_cycles;
    logic [BUS_W-1:0] exp_bus;
    ce_cycles = 0;
    exp_bus   = load_bus();
    for (int c = 0; c < 100 && arr_ce1; c++) begin
      checks++;
      if ({arr_ce0, arr_index, in_ready} !== {(ld_idx < 3'd4), ld_idx, 1'b0}) begin
        errors++;
        $display("FAIL rot_ctrl cyc %0d ce0/index/ready got %b exp %b", c,
                 {arr_ce0, arr_index, in_ready}, {(ld_idx < 3'd4), ld_idx, 1'b0});
      end
      checks++;
      if (arr_data_in !== exp_bus) begin
        errors++;
        $display("FAIL rot_data_in cyc %0d got %h exp %h", c, arr_data_in, exp_bus);
      end
      ce_cycles++;
      @(negedge clk);
    end
    checks++;
    if (ce_cycles != NUM_ITER) begin
      errors++;
      $display("FAIL rot_cycles got %0d exp %0d", ce_cycles, NUM_ITER);
    end
  endtask

  // mode 0: always ready, 1: 1010.. toggle, 2: random
  task automatic drain_job(input int mode);
    int beats;
    logic held, rdy;
    word_t hx, hy;
    logic [2*WIDTH-1:0] e;
    beats = 0;
    held  = 1'b0;
    hx    = '0;
    hy    = '0;
    for (int c = 0; c < 200 && beats < N_LANE; c++) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 2) == 0) : 1'($urandom_range(0, 1));
      out_ready = rdy;
      if (out_valid) begin
        if (held) begin
          checks++;
          if ({out_y, out_x} !== {hy, hx}) begin
            errors++;
            $display("FAIL stall_hold beat %0d got %h exp %h", beats, {out_y, out_x}, {hy, hx});
          end
        end
        if (rdy) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          checks++;
          if ({out_y, out_x} !== e) begin
            errors++;
            $display("FAIL out_data beat %0d got %h exp %h", beats, {out_y, out_x}, e);
          end
          checks++;
          if (out_last !== (beats == N_LANE - 1)) begin
            errors++;
            $display("FAIL out_last beat %0d got %b exp %b", beats, out_last, (beats == N_LANE - 1));
          end
          beats++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hx   = out_x;
          hy   = out_y;
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (beats != N_LANE) begin
      errors++;
      $display("FAIL drain_beats got %0d exp %0d", beats, N_LANE);
    end
    checks++;
    if ({busy, out_valid, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL drain_idle busy/valid/ready got %b exp 001", {busy, out_valid, in_ready});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, arr_ce0, arr_ce1, out_last, arr_index} !== 9'b100000000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 100000000",
               {in_ready, out_valid, busy, arr_ce0, arr_ce1, out_last, arr_index});
    end
    checks++;
    if ({arr_data_in, out_x, out_y} !== '0) begin
      errors++;
      $display("FAIL reset_buffers got %h/%h/%h exp 0", arr_data_in, out_x, out_y);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ideal();
    gen_job(3'd0);
    for (int i = 0; i < N_LANE; i++) begin
      ld_x[i] = word_t'(i + 1);
      ld_y[i] = word_t'(16 * i);
    end
    drive_load(0);
    watch_rotate();
    predict();
    drain_job(0);
  endtask

  task automatic test_pivot_high();
    gen_job(3'd5);
    drive_load(0);
    watch_rotate();
    predict();
    drain_job(0);
  endtask

  task automatic test_stall();
    gen_job(WIDTH_INDEX'($urandom_range(0, 7)));
    drive_load(0);
    watch_rotate();
    predict();
    drain_job(1);
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    gen_job(3'd2);
    drive_load(0);
    repeat (6) @(negedge clk);
    checks++;
    if (arr_ce1 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_rotating ce1 got %b exp 1", arr_ce1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({arr_ce0, arr_ce1, out_valid, busy, in_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL midrst_state ce0/ce1/valid/busy/ready got %b exp 00001",
               {arr_ce0, arr_ce1, out_valid, busy, in_ready});
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid || busy) stray++;
    end
    out_ready = 1'b0;
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL midrst_no_output stray cycles got %0d exp 0", stray);
    end
    gen_job(3'd6);
    drive_load(1);
    watch_rotate();
    predict();
    drain_job(2);
  endtask

`ifdef SCALE_COMP_EN
  task automatic test_scale();
    gen_job(3'd0);
    for (int i = 0; i < N_LANE; i++) begin
      direct_bus[i*WIDTH +: WIDTH]          = (i % 2 == 0) ? 24'h100000 : 24'hF00000;
      direct_bus[(N_LANE+i)*WIDTH +: WIDTH] = word_t'($urandom);
    end
    use_direct = 1'b1;
    drive_load(0);
    watch_rotate();
    for (int i = 0; i < N_LANE; i++)
      exp_q.push_back({k_mul(direct_bus[(N_LANE+i)*WIDTH +: WIDTH]),
                       (i % 2 == 0) ? 24'h09B800 : 24'hF64800});
    drain_job(0);
    use_direct = 1'b0;
  endtask
`endif

  task automatic test_gaps();
    gen_job(WIDTH_INDEX'($urandom_range(0, 7)));
    drive_load(3);
    watch_rotate();
    predict();
    drain_job(0);
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 5; j++) begin
      gen_job(WIDTH_INDEX'($urandom_range(0, 7)));
      drive_load($urandom_range(0, 2));
      watch_rotate();
      predict();
      drain_job(2);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_pivot_high();
    test_stall();
    test_reset_mid();
`ifdef SCALE_COMP_EN
    test_scale();
`endif
    test_gaps();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d entries exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
